// File: rtl/multiplier_control_unit.sv
// Sequencer for the radix-2 Booth sequential multiplier: clears and initialises
// the (2n+1)-bit product register, runs n evaluate/shift iterations, pulses done.
module multiplier_control_unit #(
  parameter int n = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               productLsbs,
  output logic                     controlledRstSignal,
  output logic                     load,
  output logic                     lowerSelect,
  output logic [1:0]               aluOp,
  output logic                     shiftRight,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(n+1)-1:0]   count
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    INIT  = 3'd2,
    EVAL  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Strobes depend only on state; aluOp in EVAL also looks at the register's own LSBs.
  always_comb begin
    state_next          = state_reg;
    count_next          = count_reg;
    controlledRstSignal = 1'b0;
    load                = 1'b0;
    lowerSelect         = 1'b0;
    aluOp               = 2'b00;
    shiftRight          = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        busy                = 1'b1;
        controlledRstSignal = 1'b1;
        count_next          = '0;
        state_next          = INIT;
      end
      INIT: begin
        busy        = 1'b1;
        load        = 1'b1;
        lowerSelect = 1'b1;
        state_next  = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        load = 1'b1;
        case (productLsbs)
          2'b10:   aluOp = 2'b10;
          2'b01:   aluOp = 2'b01;
          default: aluOp = 2'b00;
        endcase
        state_next = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        shiftRight = 1'b1;
        count_next = count_reg + CW'(1);
        state_next = (count_next == LAST) ? DONE : EVAL;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign count = count_reg;

endmodule

// File: tb/tb_multiplier_control_unit.sv
// Bench for multiplier_control_unit: three widths (8, 2, 16) share one stimulus,
// each paired with a behavioural product register and a cycle-position model.
module tb_multiplier_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        force_en;
  logic [1:0]  force_val;
  logic [15:0] mcand;
  logic [15:0] mplier;

  always #5 clk = ~clk;

  // out_s bits: [7] clear, [6] load, [5] lowerSelect, [4:3] aluOp, [2] shift, [1] busy, [0] done
  logic [7:0] out_s  [3];
  logic [4:0] cnt_s  [3];
  logic [1:0] lsbs_s [3];
  longint     acc_m  [3];
  longint     q_m    [3];
  logic       qm1_m  [3];
  int         k_m    [3];
  int         cnt_m  [3];
  int         done_cyc [3];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         check_en = 1'b0;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 16;
  endfunction

  function automatic longint sx(input longint v, input int w);
    longint m;
    longint r;
    m = (longint'(1) << w) - 1;
    r = v & m;
    if (((r >> (w - 1)) & 1) != 0) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic longint prod_view(input int i);
    longint m;
    m = (longint'(1) << wid(i)) - 1;
    return ((acc_m[i] & m) << wid(i)) | q_m[i];
  endfunction

  function automatic longint exp_prod(input int i);
    return (sx(longint'(mcand), wid(i)) * sx(longint'(mplier), wid(i))) &
           ((longint'(1) << (2 * wid(i))) - 1);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle count %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W  = (gi == 0) ? 8 : (gi == 1) ? 2 : 16;
    localparam int CW = $clog2(W + 1);
    logic          clr_w, load_w, lsel_w, shift_w, busy_w, done_w;
    logic [1:0]    alu_w;
    logic [CW-1:0] cnt_w;

    assign lsbs_s[gi] = force_en ? force_val : {q_m[gi][0], qm1_m[gi]};

    multiplier_control_unit #(.n(W)) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .productLsbs         (lsbs_s[gi]),
      .controlledRstSignal (clr_w),
      .load                (load_w),
      .lowerSelect         (lsel_w),
      .aluOp               (alu_w),
      .shiftRight          (shift_w),
      .busy                (busy_w),
      .done                (done_w),
      .count               (cnt_w)
    );

    assign out_s[gi] = {clr_w, load_w, lsel_w, alu_w, shift_w, busy_w, done_w};
    assign cnt_s[gi] = 5'(cnt_w);
  end

  // Position model: k = cycles since start was accepted (0 = idle).
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          k_m[i]   = 0;
          cnt_m[i] = 0;
        end else begin
          if (k_m[i] == 0)                  k_m[i] = start ? 1 : 0;
          else if (k_m[i] == 2*wid(i) + 3)  k_m[i] = 0;
          else                              k_m[i] = k_m[i] + 1;
          if (k_m[i] >= 3)      cnt_m[i] = (k_m[i] - 3) / 2;
          else if (k_m[i] == 2) cnt_m[i] = 0;
        end
      end
    end
  end

  // Product register with an exact-width accumulator, driven by the DUT strobes.
  initial begin
    logic [7:0] s;
    longint     mc;
    int         w;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        s  = out_s[i];
        w  = wid(i);
        mc = sx(longint'(mcand), w);
        if (s[7]) begin
          acc_m[i] = 0;
          q_m[i]   = 0;
          qm1_m[i] = 1'b0;
        end else if (s[6]) begin
          if (s[4:3] == 2'b01)      acc_m[i] = acc_m[i] + mc;
          else if (s[4:3] == 2'b10) acc_m[i] = acc_m[i] - mc;
          if (s[5]) q_m[i] = longint'(mplier) & ((longint'(1) << w) - 1);
        end else if (s[2]) begin
          qm1_m[i] = q_m[i][0];
          q_m[i]   = (q_m[i] >> 1) | ((acc_m[i] & 1) << (w - 1));
          acc_m[i] = acc_m[i] >>> 1;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the position model.
  initial begin
    int         w;
    int         k;
    bit         ld;
    bit         sh;
    logic [1:0] booth;
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      if (check_en) begin
        for (int i = 0; i < 3; i++) begin
          w  = wid(i);
          k  = k_m[i];
          ld = (k == 2) || (k >= 3 && k <= 2*w + 1 && (k % 2) == 1);
          sh = (k >= 4 && k <= 2*w + 2 && (k % 2) == 0);
          booth = 2'b00;
          if (ld && k != 2) begin
            if (lsbs_s[i] == 2'b10)      booth = 2'b10;
            else if (lsbs_s[i] == 2'b01) booth = 2'b01;
          end
          exp_v = {k == 1, ld, k == 2, booth, sh, k != 0, k == 2*w + 3};
          check($sformatf("n%0d_outputs", w), out_s[i], exp_v);
          check($sformatf("n%0d_count", w), cnt_s[i], cnt_m[i]);
          check($sformatf("n%0d_exclusive", w),
                ($countones({out_s[i][7], out_s[i][6], out_s[i][2]}) <= 1) ? 1 : 0, 1);
          if (out_s[i][0]) done_cyc[i] = cyc;
          if (k == 2*w + 3 && !force_en)
            check($sformatf("n%0d_product", w), prod_view(i), exp_prod(i));
        end
      end
    end
  end

  task automatic run_case(input logic [15:0] mc, input logic [15:0] mp, input logic [15:0] exp8);
    int e0;
    bit seen;
    mcand = mc;
    mplier = mp;
    start = 1'b1;
    @(posedge clk); #1; e0 = cyc; #1; start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!seen && out_s[0][0]) begin
        seen = 1'b1;
        check("n8_done_cycle", c, 19);
        check("n8_product_literal", prod_view(0), longint'(exp8));
        check("n8_count_at_done", cnt_s[0], 8);
      end
    end
    check("n8_done_seen", seen ? 1 : 0, 1);
    check("n2_done_cycle", done_cyc[1] - e0 + 1, 7);
    check("n16_done_cycle", done_cyc[2] - e0 + 1, 35);
    $display("run mcand=%0h mplier=%0h n8 product=%0h", mc, mp, prod_view(0));
    @(posedge clk); #2;
  endtask

  task automatic decode_case(input logic [1:0] lsbs, input logic [1:0] exp_op);
    force_en  = 1'b1;
    force_val = lsbs;
    start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("eval_aluop_cycle3", out_s[0][4:3], exp_op);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("eval_aluop_cycle5", out_s[0][4:3], exp_op);
    $display("decode lsbs=%b aluOp=%b", lsbs, out_s[0][4:3]);
    repeat (40) @(posedge clk);
    #2;
    force_en = 1'b0;
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    start = 1'b0;
    force_en = 1'b0;
    force_val = 2'b00;
    mcand = 16'h0000;
    mplier = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    check_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", out_s[0], 0);
    check("reset_count", cnt_s[0], 0);
    @(posedge clk); #2;

    run_case(16'hFFFD, 16'h0005, 16'hFFF1);
    run_case(16'h007F, 16'hFF80, 16'hC080);
    run_case(16'hFF80, 16'hFF80, 16'h4000);

    decode_case(2'b10, 2'b10);
    decode_case(2'b01, 2'b01);
    decode_case(2'b00, 2'b00);
    decode_case(2'b11, 2'b00);

    // start pulsed in EVAL and held through DONE: restart only after one IDLE cycle
    mcand = 16'h0007;
    mplier = 16'hFFFA;
    start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (4) @(posedge clk);
    #2; start = 1'b1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("held_start_done_c19", out_s[0][0], 1);
    @(posedge clk);
    @(negedge clk);
    check("held_start_idle_clear", out_s[0][7], 0);
    check("held_start_idle_busy", out_s[0][1], 0);
    @(posedge clk); #2; start = 1'b0;
    @(negedge clk);
    check("held_start_restart_clear", out_s[0][7], 1);
    $display("held start: restart clear observed=%b", out_s[0][7]);
    repeat (45) @(posedge clk);
    #2;

    // reset during the third SHIFT aborts without a done pulse
    start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (7) @(posedge clk);
    #2; rst = 1'b1;
    @(negedge clk);
    check("third_shift_strobe", out_s[0][2], 1);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", out_s[0], 0);
    check("abort_count", cnt_s[0], 0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_s[0][0]) dones = dones + 1;
    end
    check("abort_no_done", dones, 0);
    $display("abort: done pulses after reset=%0d", dones);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, cycle count %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
